// File: rtl/csr_regfile_if.sv
// Writeback-stage CSR port: register access plus exception/ERTN commit.
interface csr_regfile_if;
    logic [13:0] csr_num;
    logic        csr_re;
    logic [31:0] csr_rvalue;
    logic        csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        ertn_flush;
    logic        wb_ex;
    logic [31:0] wb_pc;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_vaddr;

    modport master (
        output csr_num, csr_re, csr_we, csr_wmask, csr_wvalue,
        output ertn_flush, wb_ex, wb_pc, wb_ecode, wb_esubcode, wb_vaddr,
        input  csr_rvalue
    );

    modport slave (
        input  csr_num, csr_re, csr_we, csr_wmask, csr_wvalue,
        input  ertn_flush, wb_ex, wb_pc, wb_ecode, wb_esubcode, wb_vaddr,
        output csr_rvalue
    );
endinterface

// File: rtl/csr_regfile.sv
// LoongArch CSR file: masked CSR access, exception/ERTN state, stable timer
// and interrupt collection for the writeback stage.
module csr_regfile #(
    parameter logic [31:0] COREID = 32'h0
) (
    input  logic                clk,
    input  logic                reset,
    csr_regfile_if.slave        csr,
    input  logic [7:0]          hw_int_in,
    input  logic                ipi_int_in,
    output logic [31:0]         ex_entry,
    output logic [31:0]         ertn_pc,
    output logic                has_int
);
    localparam int unsigned XLEN     = 32;
    localparam int unsigned NUM_SAVE = 4;

    localparam logic [13:0] CSR_CRMD   = 14'h000;
    localparam logic [13:0] CSR_PRMD   = 14'h001;
    localparam logic [13:0] CSR_ECFG   = 14'h004;
    localparam logic [13:0] CSR_ESTAT  = 14'h005;
    localparam logic [13:0] CSR_ERA    = 14'h006;
    localparam logic [13:0] CSR_BADV   = 14'h007;
    localparam logic [13:0] CSR_EENTRY = 14'h00c;
    localparam logic [13:0] CSR_SAVE0  = 14'h030;
    localparam logic [13:0] CSR_SAVE1  = 14'h031;
    localparam logic [13:0] CSR_SAVE2  = 14'h032;
    localparam logic [13:0] CSR_SAVE3  = 14'h033;
    localparam logic [13:0] CSR_TID    = 14'h040;
    localparam logic [13:0] CSR_TCFG   = 14'h041;
    localparam logic [13:0] CSR_TVAL   = 14'h042;
    localparam logic [13:0] CSR_TICLR  = 14'h044;

    // Software-writable bits of each register
    localparam logic [XLEN-1:0] WR_CRMD   = 32'h0000_001F;
    localparam logic [XLEN-1:0] WR_PRMD   = 32'h0000_0007;
    localparam logic [XLEN-1:0] WR_ECFG   = 32'h0000_1BFF;
    localparam logic [XLEN-1:0] WR_ESTAT  = 32'h0000_0003;
    localparam logic [XLEN-1:0] WR_EENTRY = 32'hFFFF_FFC0;
    localparam logic [XLEN-1:0] WR_FULL   = 32'hFFFF_FFFF;

    localparam logic [XLEN-1:0] CRMD_RST  = 32'h0000_0008;

    localparam logic [5:0] ECODE_ADEF = 6'h8;
    localparam logic [5:0] ECODE_ALE  = 6'h9;

    logic [XLEN-1:0] crmd_q,   crmd_d;
    logic [XLEN-1:0] prmd_q,   prmd_d;
    logic [XLEN-1:0] ecfg_q,   ecfg_d;
    logic [XLEN-1:0] estat_q,  estat_d;
    logic [XLEN-1:0] era_q,    era_d;
    logic [XLEN-1:0] badv_q,   badv_d;
    logic [XLEN-1:0] eentry_q, eentry_d;
    logic [XLEN-1:0] save_q [NUM_SAVE];
    logic [XLEN-1:0] save_d [NUM_SAVE];
    logic [XLEN-1:0] tid_q,    tid_d;
    logic [XLEN-1:0] tcfg_q,   tcfg_d;
    logic [XLEN-1:0] tval_q,   tval_d;
    logic            timer_en_q, timer_en_d;

    logic            sw_we;
    logic            tcfg_wr;
    logic            ticlr_clr;
    logic            timer_fire;
    logic [XLEN-1:0] rdata;

    // Masked merge restricted to the register's writable bits
    function automatic logic [XLEN-1:0] merge(
        input logic [XLEN-1:0] old,
        input logic [XLEN-1:0] writable,
        input logic [XLEN-1:0] wmask,
        input logic [XLEN-1:0] wvalue
    );
        logic [XLEN-1:0] m;
        m = wmask & writable;
        return (old & ~m) | (wvalue & m);
    endfunction

    // Next-state: software write, exception/ERTN commit, interrupt sampling, timer
    always_comb begin
        crmd_d     = crmd_q;
        prmd_d     = prmd_q;
        ecfg_d     = ecfg_q;
        estat_d    = estat_q;
        era_d      = era_q;
        badv_d     = badv_q;
        eentry_d   = eentry_q;
        save_d     = save_q;
        tid_d      = tid_q;
        tcfg_d     = tcfg_q;
        tval_d     = tval_q;
        timer_en_d = timer_en_q;
        tcfg_wr    = 1'b0;
        ticlr_clr  = 1'b0;
        timer_fire = 1'b0;

        sw_we = csr.csr_we & ~csr.wb_ex & ~csr.ertn_flush;

        if (sw_we) begin
            case (csr.csr_num)
                CSR_CRMD:   crmd_d   = merge(crmd_q,   WR_CRMD,   csr.csr_wmask, csr.csr_wvalue);
                CSR_PRMD:   prmd_d   = merge(prmd_q,   WR_PRMD,   csr.csr_wmask, csr.csr_wvalue);
                CSR_ECFG:   ecfg_d   = merge(ecfg_q,   WR_ECFG,   csr.csr_wmask, csr.csr_wvalue);
                CSR_ESTAT:  estat_d  = merge(estat_q,  WR_ESTAT,  csr.csr_wmask, csr.csr_wvalue);
                CSR_ERA:    era_d    = merge(era_q,    WR_FULL,   csr.csr_wmask, csr.csr_wvalue);
                CSR_BADV:   badv_d   = merge(badv_q,   WR_FULL,   csr.csr_wmask, csr.csr_wvalue);
                CSR_EENTRY: eentry_d = merge(eentry_q, WR_EENTRY, csr.csr_wmask, csr.csr_wvalue);
                CSR_SAVE0:  save_d[0] = merge(save_q[0], WR_FULL, csr.csr_wmask, csr.csr_wvalue);
                CSR_SAVE1:  save_d[1] = merge(save_q[1], WR_FULL, csr.csr_wmask, csr.csr_wvalue);
                CSR_SAVE2:  save_d[2] = merge(save_q[2], WR_FULL, csr.csr_wmask, csr.csr_wvalue);
                CSR_SAVE3:  save_d[3] = merge(save_q[3], WR_FULL, csr.csr_wmask, csr.csr_wvalue);
                CSR_TID:    tid_d    = merge(tid_q,    WR_FULL,   csr.csr_wmask, csr.csr_wvalue);
                CSR_TCFG: begin
                    tcfg_d  = merge(tcfg_q, WR_FULL, csr.csr_wmask, csr.csr_wvalue);
                    tcfg_wr = 1'b1;
                end
                CSR_TICLR:  ticlr_clr = csr.csr_wmask[0] & csr.csr_wvalue[0];
                default: ;
            endcase
        end

        if (csr.wb_ex) begin
            prmd_d             = {prmd_q[31:3], crmd_q[2:0]};
            crmd_d             = {crmd_q[31:3], 3'b000};
            estat_d[21:16]     = csr.wb_ecode;
            estat_d[30:22]     = csr.wb_esubcode;
            era_d              = csr.wb_pc;
            if (csr.wb_ecode == ECODE_ADEF || csr.wb_ecode == ECODE_ALE) begin
                badv_d = csr.wb_vaddr;
            end
        end else if (csr.ertn_flush) begin
            crmd_d = {crmd_q[31:3], prmd_q[2:0]};
        end

        estat_d[9:2] = hw_int_in;
        estat_d[12]  = ipi_int_in;

        // A TCFG write overrides whatever the counter would have done this cycle
        if (tcfg_wr) begin
            if (tcfg_d[0]) begin
                tval_d     = {tcfg_d[31:2], 2'b00};
                timer_en_d = 1'b1;
            end else begin
                timer_en_d = 1'b0;
            end
        end else if (timer_en_q) begin
            if (tval_q != '0) begin
                tval_d = tval_q - 32'd1;
            end else begin
                timer_fire = 1'b1;
                if (tcfg_q[1]) begin
                    tval_d = {tcfg_q[31:2], 2'b00};
                end else begin
                    timer_en_d = 1'b0;
                end
            end
        end

        // Expiry beats a same-cycle clear so the event is never dropped
        if (timer_fire) begin
            estat_d[11] = 1'b1;
        end else if (ticlr_clr) begin
            estat_d[11] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            crmd_q     <= CRMD_RST;
            prmd_q     <= '0;
            ecfg_q     <= '0;
            estat_q    <= '0;
            era_q      <= '0;
            badv_q     <= '0;
            eentry_q   <= '0;
            for (int i = 0; i < NUM_SAVE; i++) begin
                save_q[i] <= '0;
            end
            tid_q      <= COREID;
            tcfg_q     <= '0;
            tval_q     <= '0;
            timer_en_q <= 1'b0;
        end else begin
            crmd_q     <= crmd_d;
            prmd_q     <= prmd_d;
            ecfg_q     <= ecfg_d;
            estat_q    <= estat_d;
            era_q      <= era_d;
            badv_q     <= badv_d;
            eentry_q   <= eentry_d;
            for (int i = 0; i < NUM_SAVE; i++) begin
                save_q[i] <= save_d[i];
            end
            tid_q      <= tid_d;
            tcfg_q     <= tcfg_d;
            tval_q     <= tval_d;
            timer_en_q <= timer_en_d;
        end
    end

    // Zero-latency read of the current (pre-write) register state
    always_comb begin
        rdata = '0;
        if (csr.csr_re) begin
            case (csr.csr_num)
                CSR_CRMD:   rdata = crmd_q;
                CSR_PRMD:   rdata = prmd_q;
                CSR_ECFG:   rdata = ecfg_q;
                CSR_ESTAT:  rdata = estat_q;
                CSR_ERA:    rdata = era_q;
                CSR_BADV:   rdata = badv_q;
                CSR_EENTRY: rdata = eentry_q;
                CSR_SAVE0:  rdata = save_q[0];
                CSR_SAVE1:  rdata = save_q[1];
                CSR_SAVE2:  rdata = save_q[2];
                CSR_SAVE3:  rdata = save_q[3];
                CSR_TID:    rdata = tid_q;
                CSR_TCFG:   rdata = tcfg_q;
                CSR_TVAL:   rdata = tval_q;
                default:    rdata = '0;
            endcase
        end
    end

    assign csr.csr_rvalue = rdata;
    assign ex_entry       = eentry_q;
    assign ertn_pc        = era_q;
    assign has_int        = crmd_q[2] & (|(estat_q[12:0] & ecfg_q[12:0]));

endmodule

// File: tb/tb_csr_regfile.sv
// Bench for csr_regfile: vector table, hand-written timer/exception sequences,
// then random traffic against a field-level reference model.
module tb_csr_regfile;
    localparam logic [31:0] COREID = 32'h0000_00A5;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  hw_int_in;
    logic        ipi_int_in;
    logic [31:0] ex_entry;
    logic [31:0] ertn_pc;
    logic        has_int;

    csr_regfile_if bus();

    csr_regfile #(.COREID(COREID)) dut (
        .clk        (clk),
        .reset      (reset),
        .csr        (bus),
        .hw_int_in  (hw_int_in),
        .ipi_int_in (ipi_int_in),
        .ex_entry   (ex_entry),
        .ertn_pc    (ertn_pc),
        .has_int    (has_int)
    );

    always #50 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: architectural fields, not register words
    bit [1:0]  m_plv, m_pplv, m_is_sw;
    bit        m_ie, m_da, m_pg, m_pie, m_is_timer, m_is_ipi;
    bit [12:0] m_lie;
    bit [7:0]  m_is_hw;
    bit [5:0]  m_ecode;
    bit [8:0]  m_esub;
    bit [31:0] m_era, m_badv, m_tid, m_tval;
    bit [25:0] m_eva;
    bit [31:0] m_save [4];
    bit        m_ten_cfg, m_tper, m_trun;
    bit [29:0] m_tinit;

    function automatic logic [12:0] m_is_vec();
        return {m_is_ipi, m_is_timer, 1'b0, m_is_hw, m_is_sw};
    endfunction

    function automatic logic [31:0] m_read(input logic [13:0] a);
        case (a)
            14'h000: return {27'b0, m_pg, m_da, m_ie, m_plv};
            14'h001: return {29'b0, m_pie, m_pplv};
            14'h004: return {19'b0, m_lie};
            14'h005: return {1'b0, m_esub, m_ecode, 3'b0, m_is_vec()};
            14'h006: return m_era;
            14'h007: return m_badv;
            14'h00c: return {m_eva, 6'b0};
            14'h030, 14'h031, 14'h032, 14'h033: return m_save[a[1:0]];
            14'h040: return m_tid;
            14'h041: return {m_tinit, m_tper, m_ten_cfg};
            14'h042: return m_tval;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic m_has_int();
        return m_ie && ((m_is_vec() & m_lie) != 13'h0);
    endfunction

    task automatic model_reset();
        m_plv = 0; m_ie = 0; m_da = 1; m_pg = 0;
        m_pplv = 0; m_pie = 0; m_lie = 0;
        m_is_sw = 0; m_is_hw = 0; m_is_timer = 0; m_is_ipi = 0;
        m_ecode = 0; m_esub = 0; m_era = 0; m_badv = 0; m_eva = 0;
        for (int i = 0; i < 4; i++) m_save[i] = 0;
        m_tid = COREID; m_ten_cfg = 0; m_tper = 0; m_tinit = 0;
        m_tval = 0; m_trun = 0;
    endtask

    task automatic model_clock();
        logic [31:0] w;
        logic [13:0] a;
        bit fire, clr, wr_ok;
        if (reset) begin
            model_reset();
        end else begin
            a     = bus.csr_num;
            wr_ok = bus.csr_we && !bus.wb_ex && !bus.ertn_flush;
            w     = (m_read(a) & ~bus.csr_wmask) | (bus.csr_wvalue & bus.csr_wmask);
            fire  = 0;
            if (wr_ok && a == 14'h041) begin
                if (w[0]) begin
                    m_tval = {w[31:2], 2'b00};
                    m_trun = 1;
                end else begin
                    m_trun = 0;
                end
            end else if (m_trun) begin
                if (m_tval != 0) begin
                    m_tval = m_tval - 32'd1;
                end else begin
                    fire = 1;
                    if (m_tper) m_tval = {m_tinit, 2'b00};
                    else        m_trun = 0;
                end
            end
            clr = wr_ok && a == 14'h044 && w[0];
            if (fire)     m_is_timer = 1;
            else if (clr) m_is_timer = 0;
            m_is_hw  = hw_int_in;
            m_is_ipi = ipi_int_in;
            if (bus.wb_ex) begin
                m_pplv  = m_plv;
                m_pie   = m_ie;
                m_plv   = 0;
                m_ie    = 0;
                m_ecode = bus.wb_ecode;
                m_esub  = bus.wb_esubcode;
                m_era   = bus.wb_pc;
                if (bus.wb_ecode == 6'h8 || bus.wb_ecode == 6'h9) m_badv = bus.wb_vaddr;
            end else if (bus.ertn_flush) begin
                m_plv = m_pplv;
                m_ie  = m_pie;
            end else if (bus.csr_we) begin
                case (a)
                    14'h000: {m_pg, m_da, m_ie, m_plv} = w[4:0];
                    14'h001: {m_pie, m_pplv} = w[2:0];
                    14'h004: m_lie = w[12:0] & 13'h1BFF;
                    14'h005: m_is_sw = w[1:0];
                    14'h006: m_era = w;
                    14'h007: m_badv = w;
                    14'h00c: m_eva = w[31:6];
                    14'h030, 14'h031, 14'h032, 14'h033: m_save[a[1:0]] = w;
                    14'h040: m_tid = w;
                    14'h041: {m_tinit, m_tper, m_ten_cfg} = w;
                    default: ;
                endcase
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input logic exp);
        check(name, {31'b0, has_int}, {31'b0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic idle();
        bus.csr_num = 14'h0; bus.csr_re = 1'b0; bus.csr_we = 1'b0;
        bus.csr_wmask = 32'h0; bus.csr_wvalue = 32'h0;
        bus.ertn_flush = 1'b0; bus.wb_ex = 1'b0; bus.wb_pc = 32'h0;
        bus.wb_ecode = 6'h0; bus.wb_esubcode = 9'h0; bus.wb_vaddr = 32'h0;
    endtask

    task automatic wr(input logic [13:0] a, input logic [31:0] v, input logic [31:0] m);
        idle();
        bus.csr_num = a; bus.csr_we = 1'b1; bus.csr_wvalue = v; bus.csr_wmask = m;
        tick();
        idle();
    endtask

    task automatic rd_mask(input logic [13:0] a, input logic [31:0] m, input logic [31:0] exp,
                           input string name);
        bus.csr_num = a; bus.csr_re = 1'b1; bus.csr_we = 1'b0;
        #1;
        check(name, bus.csr_rvalue & m, exp);
    endtask

    task automatic rd(input logic [13:0] a, input logic [31:0] exp, input string name);
        rd_mask(a, 32'hFFFF_FFFF, exp, name);
    endtask

    typedef struct {
        logic [13:0] num;
        logic [31:0] val;
        logic [31:0] mask;
        logic [31:0] exp_rd;
        logic        exp_int;
    } vec_t;

    vec_t vecs [13];
    logic [13:0] addrs [16] = '{14'h000, 14'h001, 14'h004, 14'h005, 14'h006, 14'h007,
                                14'h00c, 14'h030, 14'h031, 14'h032, 14'h033, 14'h040,
                                14'h041, 14'h042, 14'h044, 14'h002};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{14'h000, 32'h0000_0007, 32'h0000_0004, 32'h0000_000C, 1'b0};
        vecs[1]  = '{14'h005, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0003, 1'b0};
        vecs[2]  = '{14'h004, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_1BFF, 1'b1};
        vecs[3]  = '{14'h001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0007, 1'b1};
        vecs[4]  = '{14'h00c, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFC0, 1'b1};
        vecs[5]  = '{14'h031, 32'h1234_5678, 32'hFFFF_0000, 32'h1234_0000, 1'b1};
        vecs[6]  = '{14'h040, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 1'b1};
        vecs[7]  = '{14'h042, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        vecs[8]  = '{14'h044, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        vecs[9]  = '{14'h002, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        vecs[10] = '{14'h006, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 32'h0505_0505, 1'b1};
        vecs[11] = '{14'h005, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
        vecs[12] = '{14'h000, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};

        reset = 1'b1; hw_int_in = 8'h0; ipi_int_in = 1'b0;
        idle();
        repeat (3) tick();
        reset = 1'b0;

        // Reset state
        rd(14'h000, 32'h8, "rst_crmd");
        rd(14'h005, 32'h0, "rst_estat");
        rd(14'h040, COREID, "rst_tid");
        bus.csr_re = 1'b0; #1;
        check("rst_re_low", bus.csr_rvalue, 32'h0);
        check_int("rst_has_int", 1'b0);
        check("rst_ex_entry", ex_entry, 32'h0);
        check("rst_ertn_pc", ertn_pc, 32'h0);

        // Masked write / read-back table
        for (int i = 0; i < 13; i++) begin
            wr(vecs[i].num, vecs[i].val, vecs[i].mask);
            rd(vecs[i].num, vecs[i].exp_rd, $sformatf("vec%0d_rd", i));
            check_int($sformatf("vec%0d_int", i), vecs[i].exp_int);
        end
        check("vec_ex_entry", ex_entry, 32'hFFFF_FFC0);

        // Exception entry with a colliding CSR write, then ERTN
        wr(14'h000, 32'h7, 32'hFFFF_FFFF);
        bus.wb_ex = 1'b1; bus.wb_ecode = 6'h9; bus.wb_esubcode = 9'h1;
        bus.wb_pc = 32'h1c00_0100; bus.wb_vaddr = 32'h1234_5673;
        bus.csr_we = 1'b1; bus.csr_num = 14'h000;
        bus.csr_wvalue = 32'hFFFF_FFFF; bus.csr_wmask = 32'hFFFF_FFFF;
        tick(); idle();
        rd(14'h000, 32'h0, "ex_crmd");
        rd(14'h001, 32'h7, "ex_prmd");
        rd(14'h006, 32'h1c00_0100, "ex_era");
        rd(14'h007, 32'h1234_5673, "ex_badv");
        rd(14'h005, 32'h0049_0000, "ex_estat");
        check("ex_ertn_pc", ertn_pc, 32'h1c00_0100);
        check_int("ex_has_int", 1'b0);
        bus.ertn_flush = 1'b1; bus.csr_we = 1'b1; bus.csr_num = 14'h000;
        bus.csr_wvalue = 32'h0; bus.csr_wmask = 32'hFFFF_FFFF;
        tick(); idle();
        rd(14'h000, 32'h7, "ertn_crmd");
        bus.wb_ex = 1'b1; bus.wb_ecode = 6'h4; bus.wb_pc = 32'h1c00_0200;
        bus.wb_vaddr = 32'hFFFF_FFFF;
        tick(); idle();
        rd(14'h007, 32'h1234_5673, "ex2_badv_hold");
        rd(14'h006, 32'h1c00_0200, "ex2_era");
        rd(14'h005, 32'h0004_0000, "ex2_estat");
        bus.ertn_flush = 1'b1;
        tick(); idle();
        rd(14'h000, 32'h7, "ertn2_crmd");

        // Periodic timer, InitVal=2
        wr(14'h004, 32'h800, 32'hFFFF_FFFF);
        wr(14'h041, 32'h0000_000B, 32'hFFFF_FFFF);
        rd(14'h042, 32'h8, "per_tval_load");
        for (int k = 1; k <= 8; k++) begin
            tick();
            rd(14'h042, 32'(8 - k), $sformatf("per_tval_%0d", k));
            check_int("per_no_int", 1'b0);
        end
        tick();
        rd(14'h042, 32'h8, "per_reload");
        check_int("per_fire_int", 1'b1);
        rd_mask(14'h005, 32'h1FFF, 32'h800, "per_is11");
        wr(14'h044, 32'h1, 32'h1);
        rd_mask(14'h005, 32'h1FFF, 32'h0, "per_ticlr");
        check_int("per_ticlr_int", 1'b0);
        rd(14'h042, 32'h7, "per_tval_after_clr");
        wr(14'h041, 32'h0, 32'hFFFF_FFFF);
        rd(14'h042, 32'h7, "stop_tval_hold");
        tick(); tick();
        rd(14'h042, 32'h7, "stop_tval_still");

        // One-shot timer
        wr(14'h041, 32'h9, 32'hFFFF_FFFF);
        rd(14'h042, 32'h8, "os_load");
        repeat (8) tick();
        rd(14'h042, 32'h0, "os_zero");
        check_int("os_pre_int", 1'b0);
        tick();
        rd(14'h042, 32'h0, "os_hold_zero");
        check_int("os_fire_int", 1'b1);
        wr(14'h044, 32'h1, 32'h1);
        check_int("os_clr_int", 1'b0);
        repeat (12) tick();
        rd(14'h042, 32'h0, "os_idle_tval");
        rd_mask(14'h005, 32'h1FFF, 32'h0, "os_no_refire");

        // Expiry in the same cycle as a TICLR write
        wr(14'h041, 32'h5, 32'hFFFF_FFFF);
        repeat (4) tick();
        rd(14'h042, 32'h0, "race_tval");
        wr(14'h044, 32'h1, 32'h1);
        rd_mask(14'h005, 32'h1FFF, 32'h800, "race_set_wins");
        check_int("race_int", 1'b1);
        wr(14'h044, 32'h1, 32'h1);
        rd_mask(14'h005, 32'h1FFF, 32'h0, "race_clear");

        // Hardware and IPI lines
        wr(14'h004, 32'h4, 32'hFFFF_FFFF);
        hw_int_in = 8'h01; #1;
        check_int("hw_not_yet", 1'b0);
        tick();
        check_int("hw_int", 1'b1);
        rd_mask(14'h005, 32'h1FFF, 32'h4, "hw_is2");
        wr(14'h000, 32'h0, 32'h4);
        check_int("hw_ie_off", 1'b0);
        hw_int_in = 8'h00;
        wr(14'h000, 32'h4, 32'h4);
        check_int("hw_released", 1'b0);
        wr(14'h004, 32'h1000, 32'hFFFF_FFFF);
        ipi_int_in = 1'b1;
        tick();
        check_int("ipi_int", 1'b1);
        ipi_int_in = 1'b0;
        tick();
        check_int("ipi_released", 1'b0);

        // Reset in the middle of a count
        wr(14'h041, 32'h401, 32'hFFFF_FFFF);
        repeat (3) tick();
        rd(14'h042, 32'h3FD, "mid_tval");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rd(14'h042, 32'h0, "mid_rst_tval");
        rd(14'h000, 32'h8, "mid_rst_crmd");
        rd(14'h041, 32'h0, "mid_rst_tcfg");
        repeat (3) tick();
        rd(14'h042, 32'h0, "mid_rst_stopped");
        check_int("mid_rst_int", 1'b0);

        // Random traffic against the reference model
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(0, 99) == 0);
            bus.csr_num   = addrs[$urandom_range(0, 15)];
            bus.csr_re    = ($urandom_range(0, 3) != 0);
            bus.csr_we    = ($urandom_range(0, 1) == 1);
            bus.csr_wmask = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'($urandom);
            bus.csr_wvalue = (bus.csr_num == 14'h041) ? (32'($urandom) & 32'h1F) : 32'($urandom);
            bus.wb_ex      = ($urandom_range(0, 15) == 0);
            bus.ertn_flush = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 2))
                0:       bus.wb_ecode = 6'h8;
                1:       bus.wb_ecode = 6'h9;
                default: bus.wb_ecode = 6'($urandom);
            endcase
            bus.wb_esubcode = 9'($urandom);
            bus.wb_pc       = 32'($urandom);
            bus.wb_vaddr    = 32'($urandom);
            if ($urandom_range(0, 7) == 0) hw_int_in  = 8'($urandom);
            if ($urandom_range(0, 7) == 0) ipi_int_in = ($urandom_range(0, 1) == 1);
            #1;
            check("rnd_rvalue", bus.csr_rvalue, bus.csr_re ? m_read(bus.csr_num) : 32'h0);
            check_int("rnd_has_int", m_has_int());
            check("rnd_ex_entry", ex_entry, {m_eva, 6'b0});
            check("rnd_ertn_pc", ertn_pc, m_era);
            tick();
        end
        reset = 1'b0;
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/csr_regfile.md
Name: csr_regfile

Overview:
Control/status register file for the LoongArch pipeline. It is the responder side of the writeback-stage CSR interface.
- Serves combinational CSR reads.
- Applies masked CSR writes.
- Commits exception entry and ERTN return state.
- Runs the stable timer and collects interrupt sources.
- Supplies the fetch stage with the exception entry and return PCs, and the pipeline with a pending-interrupt flag.

Parameters:
COREID, 32'h0, reset value of TID.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
csr_num  in  14  CSR address for read and write
csr_re  in  1  read enable; csr_rvalue is forced to 0 when low
csr_rvalue  out  32  read data, combinational from current register state
csr_we  in  1  write enable
csr_wmask  in  32  per-bit write mask
csr_wvalue  in  32  write data
ertn_flush  in  1  ERTN commits this cycle
wb_ex  in  1  exception commits this cycle
wb_pc  in  32  PC of the excepting instruction
wb_ecode  in  6  exception code
wb_esubcode  in  9  exception subcode
wb_vaddr  in  32  faulting virtual address
hw_int_in  in  8  hardware interrupt lines, level
ipi_int_in  in  1  inter-processor interrupt, level
ex_entry  out  32  EENTRY value (exception target PC)
ertn_pc  out  32  ERA value (ERTN target PC)
has_int  out  1  enabled interrupt pending

Behaviour:
Reset (synchronous, active-high, clk): all state returns to the values below.
- Every register resets to 0 except: CRMD=32'h8 (DA=1), TID=COREID.
- Internal timer_en resets to 0.
- Resulting outputs: has_int=0, ex_entry=0, ertn_pc=0.

Implemented registers and fields (all others read 0, writes ignored):
- CRMD 0x0: PLV[1:0], IE[2], DA[3], PG[4].
- PRMD 0x1: PPLV[1:0], PIE[2].
- ECFG 0x4: LIE[9:0], LIE[12:11]; bit10 reads 0.
- ESTAT 0x5: IS[1:0] software-writable; IS[9:2], IS[11], IS[12] hardware-owned, read-only; Ecode[21:16], EsubCode[30:22].
- ERA 0x6, BADV 0x7: 32-bit.
- EENTRY 0xc: VA[31:6]; bits [5:0] read 0.
- SAVE0-3 0x30-0x33: 32-bit.
- TID 0x40: 32-bit.
- TCFG 0x41: En[0], Periodic[1], InitVal[31:2].
- TVAL 0x42: read-only.
- TICLR 0x44: CLR[0]; always reads 0.

Read path:
- csr_rvalue = csr_re ? field-assembled value of csr_num : 0.
- Zero latency; shows pre-write state during a write cycle.

Write path:
- Field' = (old & ~csr_wmask) | (csr_wvalue & csr_wmask), applied only to writable bits.
- Committed at the clk edge.

Priority per cycle: wb_ex > ertn_flush > csr_we. csr_we is ignored in any cycle with wb_ex or ertn_flush.

wb_ex actions:
- PRMD.PPLV<=CRMD.PLV, PRMD.PIE<=CRMD.IE.
- CRMD.PLV<=0, CRMD.IE<=0.
- ESTAT.Ecode<=wb_ecode, ESTAT.EsubCode<=wb_esubcode.
- ERA<=wb_pc.
- BADV<=wb_vaddr only when wb_ecode is 6'h8 (ADEF) or 6'h9 (ALE); otherwise BADV unchanged.

ertn_flush actions: CRMD.PLV<=PRMD.PPLV, CRMD.IE<=PRMD.PIE.

Interrupt sampling, every cycle:
- IS[9:2]<=hw_int_in.
- IS[12]<=ipi_int_in.

Timer:
- TCFG write with new En=1: TVAL<={InitVal,2'b00}, timer_en<=1.
- TCFG write with new En=0: timer_en<=0, TVAL holds.
- Else, timer_en && TVAL!=0: TVAL<=TVAL-1.
- Else, timer_en && TVAL==0:
  - IS[11]<=1.
  - If Periodic, TVAL<={InitVal,2'b00}; else timer_en<=0 and TVAL holds 0.
- TICLR write with masked CLR=1 clears IS[11]. A timer set in the same cycle wins, so the event is not lost.
- TCFG write in the same cycle as a decrement or expiry: the write wins.
- A wb_ex cycle still advances the timer.

Outputs:
- has_int = CRMD.IE & |(ESTAT.IS[12:0] & ECFG.LIE[12:0]), registered-state based.
- ex_entry = {EENTRY.VA,6'b0}.
- ertn_pc = ERA.

Test Plan:
- Reset then read 0x0, 0x5, 0x40 with csr_re=1 -> 32'h8, 0, COREID; has_int=0; read with csr_re=0 -> 0.
- Write CRMD wvalue=32'h7, wmask=32'h4 -> CRMD=32'hC. Write ESTAT 32'hFFFF_FFFF with full mask -> reads 32'h3 (only IS[1:0]).
- CRMD=32'h7, wb_ex=1, ecode=6'h9, pc=32'h1c00_0100, vaddr=32'h1234_5673, csr_we=1 same cycle -> CRMD=0, PRMD=32'h7, ERA=32'h1c00_0100, BADV=32'h1234_5673, Ecode=9, write dropped. Next cycle ertn_flush -> CRMD=32'h7.
- ECFG=32'h800, CRMD.IE=1, TCFG=32'h0000_000B (InitVal=2, periodic, en) -> TVAL=8 then counts to 0; IS[11]=1 and has_int=1 on the following cycle; TVAL reloads 8. TICLR write 1 -> IS[11]=0, has_int=0.
- TCFG=32'h9 (one-shot, InitVal=2) -> single IS[11] set, TVAL stays 0, no further events.
- Drive hw_int_in=8'h01 with ECFG.LIE[2]=1, IE=1 -> has_int=1 after one clk; IE=0 -> has_int=0. Mid-count reset -> TVAL=0, timer_en=0.
